// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: widths, opcodes, FSM states.
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int ALU_CNT_W = 16;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;
  localparam logic [2:0] ALU_SRA = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two requesters, the result consumer
// and the ALU sharing arbiter.
interface alu_share_arbiter_if #(
  parameter int WIDTH = alu_pkg::ALU_WIDTH,
  parameter int CNT_W = alu_pkg::ALU_CNT_W
);

  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_A;
  logic [WIDTH-1:0] req0_B;
  logic [2:0]       req0_ALUOp;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_A;
  logic [WIDTH-1:0] req1_B;
  logic [2:0]       req1_ALUOp;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_C;
  logic [CNT_W-1:0] ops_done;

  // Client side: requesters plus the result consumer.
  modport master (
    output req0_valid, req0_A, req0_B, req0_ALUOp,
    output req1_valid, req1_A, req1_B, req1_ALUOp,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_C, ops_done
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_A, req0_B, req0_ALUOp,
    input  req1_valid, req1_A, req1_B, req1_ALUOp,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_C, ops_done
  );

endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU: add/sub wrap, bitwise and/or, logical and
// arithmetic right shift by B[4:0]; unused opcodes give zero.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUOp,
  output logic [WIDTH-1:0] C
);

  logic [4:0] shamt_s;

  // Opcode decode and result selection.
  always_comb begin
    shamt_s = B[4:0];
    C       = {WIDTH{1'b0}};
    case (ALUOp)
      ALU_ADD: C = A + B;
      ALU_SUB: C = A - B;
      ALU_AND: C = A & B;
      ALU_OR:  C = A | B;
      ALU_SRL: C = A >> shamt_s;
      ALU_SRA: C = $unsigned($signed(A) >>> shamt_s);
      default: C = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two requesters. Round-robin grant in IDLE, one
// cycle of execution on latched operands, then the result is held on the
// response channel until the consumer takes it.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = ALU_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_share_arbiter_if.slave bus
);

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_c_q, rsp_c_d;
  logic [CNT_W-1:0] ops_done_q, ops_done_d;

  logic             grant_s;
  logic             any_valid_s;
  logic             ready0_s;
  logic             ready1_s;
  logic [WIDTH-1:0] alu_c_s;

  alu_core #(.WIDTH(WIDTH)) u_alu_core (
    .A     (a_q),
    .B     (b_q),
    .ALUOp (op_q),
    .C     (alu_c_s)
  );

  // Round-robin grant: a lone requester always wins, contention goes to
  // whoever was not served last.
  always_comb begin
    any_valid_s = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_s = ~last_grant_q;
    end else if (bus.req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    ready0_s = (state_q == S_IDLE) && bus.req0_valid && (grant_s == 1'b0);
    ready1_s = (state_q == S_IDLE) && bus.req1_valid && (grant_s == 1'b1);
  end

  // FSM next state, operand capture, response register and counter update.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_c_d      = rsp_c_q;
    ops_done_d   = ops_done_q;
    case (state_q)
      S_IDLE: begin
        // Any valid means the granted requester sees ready, so it fires.
        if (any_valid_s) begin
          state_d      = S_EXEC;
          id_d         = grant_s;
          last_grant_d = grant_s;
          if (grant_s) begin
            a_d  = bus.req1_A;
            b_d  = bus.req1_B;
            op_d = bus.req1_ALUOp;
          end else begin
            a_d  = bus.req0_A;
            b_d  = bus.req0_B;
            op_d = bus.req0_ALUOp;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        state_d     = S_RESP;
        rsp_c_d     = alu_c_s;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          ops_done_d  = ops_done_q + CNT_W'(1);
        end else begin
          state_d     = S_RESP;
        end
      end
      default: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      a_q          <= {WIDTH{1'b0}};
      b_q          <= {WIDTH{1'b0}};
      op_q         <= 3'b000;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_c_q      <= {WIDTH{1'b0}};
      ops_done_q   <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_c_q      <= rsp_c_d;
      ops_done_q   <= ops_done_d;
    end
  end

  assign bus.req0_ready = ready0_s;
  assign bus.req1_ready = ready1_s;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_C      = rsp_c_q;
  assign bus.ops_done   = ops_done_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed vector table,
// reset corner sequences and randomized traffic against a reference model.
module tb_alu_share_arbiter;

  logic clk;
  logic rst_n;

  alu_share_arbiter_if bus_if ();

  alu_share_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic        lg;          // model: last granted requester
  logic [15:0] exp_ops;     // model: completed responses

  typedef struct {
    logic        v0;
    logic        v1;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [2:0]  op0;
    logic [31:0] a1;
    logic [31:0] b1;
    logic [2:0]  op1;
    logic        exp_id;
    logic [31:0] exp_c;
  } vec_t;

  vec_t vecs [12];

  localparam logic [31:0] TA = 32'h20A0_8A20;
  localparam logic [31:0] TB = 32'h1080_0810;
  localparam logic [31:0] SA = 32'hA0A0_8A20;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference ALU written from the opcode definitions with plain arithmetic.
  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    logic [31:0] q;
    sh = b[4:0];
    case (op)
      3'd0:    q = a + b;
      3'd1:    q = a + (~b) + 32'd1;
      3'd2:    q = a & b;
      3'd3:    q = a | b;
      3'd4:    q = a / (32'd1 << sh);
      3'd5: begin
        q = a / (32'd1 << sh);
        if (a[31]) q = q | ~(32'hFFFF_FFFF >> sh);
      end
      default: q = 32'd0;
    endcase
    return q;
  endfunction

  // One transaction starting at a negedge in IDLE; ends at a negedge in IDLE.
  // hold = number of RESP cycles with rsp_ready low.
  task automatic do_txn(input logic v0, input logic v1,
                        input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] op0,
                        input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] op1,
                        input logic exp_id, input logic [31:0] exp_c, input int hold);
    bus_if.req0_valid = v0;  bus_if.req0_A = a0; bus_if.req0_B = b0; bus_if.req0_ALUOp = op0;
    bus_if.req1_valid = v1;  bus_if.req1_A = a1; bus_if.req1_B = b1; bus_if.req1_ALUOp = op1;
    bus_if.rsp_ready  = (hold == 0);
    #1;
    check("grant_ready", {bus_if.req1_ready, bus_if.req0_ready}, exp_id ? 2'b10 : 2'b01);
    lg = exp_id;
    @(negedge clk);
    check("exec_rsp_valid", bus_if.rsp_valid, 1'b0);
    check("exec_ready", {bus_if.req1_ready, bus_if.req0_ready}, 2'b00);
    @(negedge clk);
    check("resp_valid", bus_if.rsp_valid, 1'b1);
    check("resp_id", bus_if.rsp_id, exp_id);
    check("resp_C", bus_if.rsp_C, exp_c);
    check("resp_ready", {bus_if.req1_ready, bus_if.req0_ready}, 2'b00);
    check("resp_ops_done", bus_if.ops_done, exp_ops);
    for (int k = 1; k <= hold; k++) begin
      @(negedge clk);
      check("hold_valid", bus_if.rsp_valid, 1'b1);
      check("hold_C", bus_if.rsp_C, exp_c);
      check("hold_id", bus_if.rsp_id, exp_id);
      check("hold_ready", {bus_if.req1_ready, bus_if.req0_ready}, 2'b00);
      check("hold_ops_done", bus_if.ops_done, exp_ops);
      if (k == hold) bus_if.rsp_ready = 1'b1;
    end
    bus_if.req0_valid = 1'b0;
    bus_if.req1_valid = 1'b0;
    @(negedge clk);
    exp_ops = exp_ops + 16'd1;
    check("idle_rsp_valid", bus_if.rsp_valid, 1'b0);
    check("idle_ops_done", bus_if.ops_done, exp_ops);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  v;
    logic        g;
    logic [31:0] ra0, rb0, ra1, rb1, rc;
    logic [2:0]  rop0, rop1;

    vecs[0]  = '{1'b1, 1'b1, TA, TB, 3'd0, TA, TB, 3'd1, 1'b0, 32'h3120_9230};
    vecs[1]  = '{1'b1, 1'b1, TA, TB, 3'd0, TA, TB, 3'd1, 1'b1, 32'h1020_8210};
    vecs[2]  = '{1'b1, 1'b1, TA, TB, 3'd2, TA, TB, 3'd3, 1'b0, 32'h0080_0800};
    vecs[3]  = '{1'b1, 1'b1, TA, TB, 3'd2, TA, TB, 3'd3, 1'b1, 32'h30A0_8A30};
    vecs[4]  = '{1'b1, 1'b0, TA, TB, 3'd0, 32'd0, 32'd0, 3'd0, 1'b0, 32'h3120_9230};
    vecs[5]  = '{1'b0, 1'b1, 32'd0, 32'd0, 3'd0, TA, TB, 3'd1, 1'b1, 32'h1020_8210};
    vecs[6]  = '{1'b0, 1'b1, 32'd0, 32'd0, 3'd0, TA, TB, 3'd2, 1'b1, 32'h0080_0800};
    vecs[7]  = '{1'b0, 1'b1, 32'd0, 32'd0, 3'd0, TA, TB, 3'd3, 1'b1, 32'h30A0_8A30};
    vecs[8]  = '{1'b1, 1'b0, SA, 32'd2, 3'd4, 32'd0, 32'd0, 3'd0, 1'b0, 32'h2828_2288};
    vecs[9]  = '{1'b1, 1'b0, SA, 32'd2, 3'd5, 32'd0, 32'd0, 3'd0, 1'b0, 32'hE828_2288};
    vecs[10] = '{1'b0, 1'b1, 32'd0, 32'd0, 3'd0, SA, 32'd2, 3'd6, 1'b1, 32'h0000_0000};
    vecs[11] = '{1'b1, 1'b0, SA, 32'd2, 3'd7, 32'd0, 32'd0, 3'd0, 1'b0, 32'h0000_0000};

    bus_if.req0_valid = 1'b0; bus_if.req0_A = 32'd0; bus_if.req0_B = 32'd0; bus_if.req0_ALUOp = 3'd0;
    bus_if.req1_valid = 1'b0; bus_if.req1_A = 32'd0; bus_if.req1_B = 32'd0; bus_if.req1_ALUOp = 3'd0;
    bus_if.rsp_ready  = 1'b0;
    lg      = 1'b1;
    exp_ops = 16'd0;

    // Reset state
    rst_n = 1'b0;
    #1;
    check("rst_ready", {bus_if.req1_ready, bus_if.req0_ready}, 2'b00);
    check("rst_rsp_valid", bus_if.rsp_valid, 1'b0);
    check("rst_rsp_id", bus_if.rsp_id, 1'b0);
    check("rst_rsp_C", bus_if.rsp_C, 32'd0);
    check("rst_ops_done", bus_if.ops_done, 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table: contention 0,1,0,1 then single requesters and all opcodes
    for (int i = 0; i < 12; i++) begin
      do_txn(vecs[i].v0, vecs[i].v1, vecs[i].a0, vecs[i].b0, vecs[i].op0,
             vecs[i].a1, vecs[i].b1, vecs[i].op1, vecs[i].exp_id, vecs[i].exp_c, 0);
      if (i == 3) check("ops_done_after_4", bus_if.ops_done, 16'd4);
    end

    // Consumer stalls for 5 cycles; last grant was 0 so req1 wins contention
    do_txn(1'b1, 1'b1, TA, TB, 3'd0, SA, 32'd2, 3'd5, 1'b1, 32'hE828_2288, 5);

    // Reset while in RESP: rsp_valid must drop without a clock edge
    bus_if.req0_valid = 1'b1; bus_if.req0_A = TA; bus_if.req0_B = TB; bus_if.req0_ALUOp = 3'd0;
    bus_if.rsp_ready  = 1'b0;
    #1;
    check("rr_ready0", bus_if.req0_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("rr_resp_valid", bus_if.rsp_valid, 1'b1);
    bus_if.req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rr_rsp_valid_async", bus_if.rsp_valid, 1'b0);
    check("rr_rsp_C", bus_if.rsp_C, 32'd0);
    check("rr_ops_done", bus_if.ops_done, 16'd0);
    #2;
    rst_n   = 1'b1;
    exp_ops = 16'd0;
    lg      = 1'b1;
    @(negedge clk);

    // Reset while in EXEC: operation discarded, req0 wins the next contention
    bus_if.req1_valid = 1'b1; bus_if.req1_A = TA; bus_if.req1_B = TB; bus_if.req1_ALUOp = 3'd3;
    #1;
    check("re_ready1", bus_if.req1_ready, 1'b1);
    @(negedge clk);
    check("re_exec_rsp_valid", bus_if.rsp_valid, 1'b0);
    bus_if.req1_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("re_rsp_valid", bus_if.rsp_valid, 1'b0);
    check("re_ops_done", bus_if.ops_done, 16'd0);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("re_idle_after", bus_if.rsp_valid, 1'b0);
    do_txn(1'b1, 1'b1, TA, TB, 3'd0, TA, TB, 3'd1, 1'b0, 32'h3120_9230, 0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 60; i++) begin
      v = 2'($urandom_range(0, 3));
      if (v == 2'b00) begin
        bus_if.req0_valid = 1'b0;
        bus_if.req1_valid = 1'b0;
        #1;
        check("rnd_idle_ready", {bus_if.req1_ready, bus_if.req0_ready}, 2'b00);
        @(negedge clk);
        check("rnd_idle_valid", bus_if.rsp_valid, 1'b0);
      end else begin
        ra0 = $urandom; rb0 = $urandom; rop0 = 3'($urandom_range(0, 7));
        ra1 = $urandom; rb1 = $urandom; rop1 = 3'($urandom_range(0, 7));
        if (v == 2'b11) g = ~lg;
        else g = v[1];
        rc = g ? ref_alu(rop1, ra1, rb1) : ref_alu(rop0, ra0, rb0);
        do_txn(v[0], v[1], ra0, rb0, rop0, ra1, rb1, rop1, g, rc, $urandom_range(0, 2));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
